resizer_block_to_raster: RTL and testbench

// - Sink for the bicubic 2x resizer's 128-bit output stream. Each input beat carries the
//   2x2 output block of one source pixel.
// - Reorders the blocks into a raster-order 32-bit pixel AXI-Stream, two output rows per

---
 rtl/resizer_block_to_raster_pkg.sv | 18 +
 rtl/resizer_block_to_raster_line_pair_buffer.sv | 35 +++
 rtl/resizer_block_to_raster.sv | 173 +++++++++++++++++
 tb/tb_resizer_block_to_raster.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/resizer_block_to_raster_pkg.sv
// rtl/resizer_block_to_raster_pkg.sv - shared constants and FSM state type for the block-to-raster sink
package resizer_pkg;

    localparam int PIX_W   = 32;
    localparam int LANE_TL = 0;
    localparam int LANE_TR = 32;
    localparam int LANE_BL = 64;
    localparam int LANE_BR = 96;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        EMIT_L   = 3'd1,
        EMIT_R   = 3'd2,
        ODD_PREF = 3'd3,
        ODD      = 3'd4
    } state_e;

endpackage

// File: rtl/resizer_block_to_raster_line_pair_buffer.sv
// rtl/resizer_block_to_raster_line_pair_buffer.sv - simple dual-port line RAM holding the bottom pixel pair of each block
module line_pair_buffer #(
    parameter int DEPTH = 320,
    parameter int AW    = 9,
    parameter int DW    = 64
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // synchronous write port; no reset so the array maps onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // registered read port; data only changes when a read is issued
    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/resizer_block_to_raster.sv
// rtl/resizer_block_to_raster.sv - reorders 2x2 output blocks into a raster 32-bit pixel stream
module resizer_block_to_raster
    import resizer_pkg::*;
#(
    parameter int IN_WIDTH  = 320,
    parameter int IN_HEIGHT = 180
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    output logic [31:0]  m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         m_axis_tuser,
    output logic         m_axis_tlast,
    output logic         o_frame_done
);

    localparam int CW = $clog2(2 * IN_WIDTH);
    localparam int AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int LW = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IN_WIDTH - 1);
    localparam logic [CW-1:0] K_LAST    = CW'(2 * IN_WIDTH - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(IN_HEIGHT - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [CW-1:0]       k_q, k_d;
    logic [LW-1:0]       line_q, line_d;
    logic [2*PIX_W-1:0]  hold_q, hold_d;
    logic                done_q, done_d;

    logic                s_ready;
    logic                wr_en;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;
    logic [2*PIX_W-1:0]  rd_data;

    logic                m_valid;
    logic [PIX_W-1:0]    m_data;
    logic                m_user;
    logic                m_last;

    // the input is only open in LOAD and never while reset is held
    assign s_ready = (state_q == LOAD) && !rstn;

    line_pair_buffer #(
        .DEPTH (IN_WIDTH),
        .AW    (AW),
        .DW    (2 * PIX_W)
    ) u_line_pair_buffer (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (AW'(col_q)),
        .wr_data_i (s_axis_tdata[LANE_BL +: 2*PIX_W]),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // state, counters, hold register and frame-done pulse
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= LOAD;
            col_q   <= '0;
            k_q     <= '0;
            line_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            k_q     <= k_d;
            line_q  <= line_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
        end
    end

    // next-state, buffer control and output mux; outputs decode registered state only
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        k_d     = k_q;
        line_d  = line_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        m_valid = 1'b0;
        m_data  = '0;
        m_user  = 1'b0;
        m_last  = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_ready && s_axis_tvalid) begin
                    hold_d  = s_axis_tdata[LANE_TL +: 2*PIX_W];
                    wr_en   = 1'b1;
                    state_d = EMIT_L;
                end
            end
            EMIT_L: begin
                m_valid = 1'b1;
                m_data  = hold_q[0 +: PIX_W];
                m_user  = (line_q == '0) && (col_q == '0);
                if (m_axis_tready) begin
                    state_d = EMIT_R;
                end
            end
            EMIT_R: begin
                m_valid = 1'b1;
                m_data  = hold_q[PIX_W +: PIX_W];
                m_last  = (col_q == COL_LAST);
                if (m_axis_tready) begin
                    if (col_q == COL_LAST) begin
                        // even row complete: prefetch the first bottom pair
                        col_d   = '0;
                        rd_en   = 1'b1;
                        rd_addr = '0;
                        state_d = ODD_PREF;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = LOAD;
                    end
                end
            end
            ODD_PREF: begin
                state_d = ODD;
            end
            ODD: begin
                m_valid = 1'b1;
                m_data  = k_q[0] ? rd_data[PIX_W +: PIX_W] : rd_data[0 +: PIX_W];
                m_last  = (k_q == K_LAST);
                if (m_axis_tready) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = LOAD;
                        if (line_q == LINE_LAST) begin
                            line_d = '0;
                            done_d = 1'b1;
                        end else begin
                            line_d = line_q + LW'(1);
                        end
                    end else if (k_q[0]) begin
                        // pair finished: fetch the next one and take a one-cycle bubble
                        k_d     = k_q + CW'(1);
                        rd_en   = 1'b1;
                        rd_addr = AW'((k_q + CW'(1)) >> 1);
                        state_d = ODD_PREF;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid;
    assign m_axis_tdata  = m_data;
    assign m_axis_tuser  = m_user;
    assign m_axis_tlast  = m_last;
    assign o_frame_done  = done_q;

endmodule

// File: tb/tb_resizer_block_to_raster.sv
// tb/tb_resizer_block_to_raster.sv - randomized self-checking bench against a raster-order reference model
module tb_resizer_block_to_raster;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int OW = 2 * W;
    localparam int OH = 2 * H;

    logic         clk;
    logic         rstn;
    logic [127:0] s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tuser;
    logic         m_axis_tlast;
    logic         o_frame_done;

    resizer_block_to_raster #(
        .IN_WIDTH  (W),
        .IN_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .o_frame_done  (o_frame_done)
    );

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
        logic        odd;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] beat_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int ready_pct = 100;
    int done_cnt  = 0;
    int out_cnt   = 0;
    int odd_viol  = 0;
    int stab_viol = 0;
    bit abort_drv = 0;
    bit acc_pending = 0;

    logic        prev_stall;
    logic [31:0] prev_d;
    logic        prev_u;
    logic        prev_l;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference: build the 2H x 2W output image from the blocks, then scan it in raster order
    task automatic push_frame(input bit encoded);
        logic [31:0] pix [OH][OW];
        logic [31:0] q [4];
        logic [31:0] rnd;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                for (int n = 0; n < 4; n++) begin
                    rnd = $urandom();
                    if (encoded) q[n] = {8'h00, 8'(r), 8'(c), 8'(n)};
                    else         q[n] = {8'h00, rnd[23:0]};
                end
                beat_q.push_back({q[3], q[2], q[1], q[0]});
                pix[2*r][2*c]       = q[0];
                pix[2*r][2*c+1]     = q[1];
                pix[2*r+1][2*c]     = q[2];
                pix[2*r+1][2*c+1]   = q[3];
            end
        end
        for (int y = 0; y < OH; y++) begin
            for (int x = 0; x < OW; x++) begin
                exp_t e;
                e.d   = pix[y][x];
                e.u   = (y == 0) && (x == 0);
                e.l   = (x == OW - 1);
                e.odd = (y % 2) == 1;
                exp_q.push_back(e);
            end
        end
    endtask

    // output monitor: randomizes downstream ready and scores every handshake
    initial begin
        m_axis_tready = 1'b0;
        prev_stall = 1'b0;
        prev_d = '0;
        prev_u = 1'b0;
        prev_l = 1'b0;
        forever begin
            @(negedge clk);
            m_axis_tready = ($urandom_range(0, 99) < ready_pct);
            if (!rstn) begin
                if (prev_stall && (!m_axis_tvalid || m_axis_tdata !== prev_d ||
                                   m_axis_tuser !== prev_u || m_axis_tlast !== prev_l))
                    stab_viol++;
                if (o_frame_done) done_cnt++;
                if (exp_q.size() > 0 && exp_q[0].odd && s_axis_tready) odd_viol++;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_pixel", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("tdata", m_axis_tdata, e.d);
                        check("tuser", 32'(m_axis_tuser), 32'(e.u));
                        check("tlast", 32'(m_axis_tlast), 32'(e.l));
                    end
                    out_cnt++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_d = m_axis_tdata;
                prev_u = m_axis_tuser;
                prev_l = m_axis_tlast;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic drive_beats(input int idle_pct);
        while (beat_q.size() > 0 && !abort_drv) begin
            bit sent;
            int wait_cyc;
            sent = 0;
            wait_cyc = 0;
            while (!sent) begin
                @(negedge clk);
                if (abort_drv) break;
                if (acc_pending) begin
                    s_axis_tvalid = 1'b0;
                    acc_pending = 0;
                end
                if (!s_axis_tvalid && $urandom_range(0, 99) >= idle_pct) begin
                    s_axis_tvalid = 1'b1;
                    s_axis_tdata  = beat_q[0];
                end
                #1;
                if (s_axis_tvalid && s_axis_tready) begin
                    sent = 1;
                    acc_pending = 1;
                end
                wait_cyc++;
                if (!sent && wait_cyc > 2000) begin
                    check("beat_timeout", 32'd1, 32'd0);
                    abort_drv = 1;
                    break;
                end
            end
            if (sent) void'(beat_q.pop_front());
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        acc_pending = 0;
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 5000) begin
            @(negedge clk);
            cnt++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic run_test(input int idle_pct, input int rdy, input int nframes, input bit encoded);
        ready_pct = rdy;
        done_cnt  = 0;
        odd_viol  = 0;
        stab_viol = 0;
        for (int f = 0; f < nframes; f++) push_frame(encoded);
        drive_beats(idle_pct);
        wait_drain();
        check("frame_done_cnt", 32'(done_cnt), 32'(nframes));
        check("odd_row_tready", 32'(odd_viol), 32'd0);
        check("hold_stable", 32'(stab_viol), 32'd0);
    endtask

    task automatic check_reset_outs();
        check("reset_outs",
              {25'd0, m_axis_tvalid, m_axis_tuser, m_axis_tlast, s_axis_tready, o_frame_done,
               1'b0, |m_axis_tdata},
              32'd0);
    endtask

    initial begin
        rstn = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outs();
        rstn = 1'b0;
        @(negedge clk);

        run_test(0, 100, 1, 1'b1);
        run_test(0, 50, 1, 1'b1);
        run_test(30, 100, 1, 1'b1);

        // reset in the middle of a frame
        ready_pct = 100;
        push_frame(1'b0);
        out_cnt = 0;
        fork
            drive_beats(0);
            begin
                int cnt;
                cnt = 0;
                while (out_cnt < 5 && cnt < 1000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("pre_reset_pixels", 32'(out_cnt >= 5), 32'd1);
                @(posedge clk);
                #2;
                rstn = 1'b1;
                abort_drv = 1;
                s_axis_tvalid = 1'b0;
            end
        join
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outs();
        end
        exp_q.delete();
        beat_q.delete();
        abort_drv = 0;
        rstn = 1'b0;
        @(negedge clk);
        run_test(0, 100, 1, 1'b0);

        run_test(0, 100, 2, 1'b1);
        run_test(30, 50, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
